// File: rtl/mem_stage.sv
// Memory-access stage: data memory, load/store sizing, branch resolve,
// and the registered MEM/WB boundary.
module mem_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_PC   = 32,
  parameter int NB_REG  = 5,
  parameter int NB_ADDR = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_MEM_stall,
  input  logic               i_MEM_reg_write,
  input  logic               i_MEM_mem_to_reg,
  input  logic               i_MEM_mem_read,
  input  logic               i_MEM_mem_write,
  input  logic               i_MEM_branch,
  input  logic               i_MEM_zero,
  input  logic [1:0]         i_MEM_size,
  input  logic               i_MEM_unsigned,
  input  logic [NB_PC-1:0]   i_MEM_branch_address,
  input  logic [NB_DATA-1:0] i_MEM_alu_result,
  input  logic [NB_DATA-1:0] i_MEM_write_data,
  input  logic [NB_REG-1:0]  i_MEM_selected_reg,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic               o_MEM_pc_src,
  output logic [NB_PC-1:0]   o_MEM_branch_address,
  output logic               o_WB_reg_write,
  output logic               o_WB_mem_to_reg,
  output logic [NB_DATA-1:0] o_WB_mem_data,
  output logic [NB_DATA-1:0] o_WB_alu_result,
  output logic [NB_REG-1:0]  o_WB_selected_reg,
  output logic               o_MEM_misaligned,
  output logic [NB_DATA-1:0] o_debug_data
);

  localparam int NB_LANE = NB_DATA / 8;

  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  logic [NB_ADDR-1:0] idx;
  logic [1:0]         off;
  logic               sz_byte;
  logic               sz_half;
  logic               sz_word;
  logic               mis;
  logic               access;
  logic               wr_en;
  logic [NB_LANE-1:0] be;
  logic [NB_DATA-1:0] wdata;
  logic [NB_DATA-1:0] rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [NB_DATA-1:0] ld_ext;
  logic [NB_DATA-1:0] ld_data;

  assign o_MEM_pc_src         = i_MEM_branch & i_MEM_zero;
  assign o_MEM_branch_address = i_MEM_branch_address;

  assign idx     = i_MEM_alu_result[NB_ADDR+1:2];
  assign off     = i_MEM_alu_result[1:0];
  assign sz_byte = (i_MEM_size == 2'b00);
  assign sz_half = (i_MEM_size == 2'b01);
  assign sz_word = i_MEM_size[1];

  assign mis    = (sz_half & off[0]) | (sz_word & (off != 2'b00));
  assign access = i_MEM_mem_read | i_MEM_mem_write;
  assign wr_en  = i_MEM_mem_write & ~i_MEM_stall & ~mis;

  always_comb begin
    be    = '0;
    wdata = i_MEM_write_data;
    unique case (1'b1)
      sz_byte: begin
        be[off] = 1'b1;
        wdata   = {NB_LANE{i_MEM_write_data[7:0]}};
      end
      sz_half: begin
        be      = off[1] ? 4'b1100 : 4'b0011;
        wdata   = {(NB_LANE/2){i_MEM_write_data[15:0]}};
      end
      default: be = '1;
    endcase
  end

  // Combinational read sees pre-edge contents, so same-cycle stores read old.
  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{off, 3'b000} +: 8];
  assign rd_half = rd_word[{off[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = rd_word;
    unique case (1'b1)
      sz_byte:
        ld_ext = {{(NB_DATA-8){~i_MEM_unsigned & rd_byte[7]}}, rd_byte};
      sz_half:
        ld_ext = {{(NB_DATA-16){~i_MEM_unsigned & rd_half[15]}}, rd_half};
      default: ld_ext = rd_word;
    endcase
  end

  assign ld_data = (i_MEM_mem_read & ~mis) ? ld_ext : '0;

  always_ff @(posedge i_clock) begin
    if (wr_en) begin
      for (int i = 0; i < NB_LANE; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_WB_reg_write    <= 1'b0;
      o_WB_mem_to_reg   <= 1'b0;
      o_WB_mem_data     <= '0;
      o_WB_alu_result   <= '0;
      o_WB_selected_reg <= '0;
      o_MEM_misaligned  <= 1'b0;
      o_debug_data      <= '0;
    end else begin
      o_debug_data <= mem[i_debug_addr];
      if (!i_MEM_stall) begin
        o_WB_reg_write    <= i_MEM_reg_write;
        o_WB_mem_to_reg   <= i_MEM_mem_to_reg;
        o_WB_mem_data     <= ld_data;
        o_WB_alu_result   <= i_MEM_alu_result;
        o_WB_selected_reg <= i_MEM_selected_reg;
        if (access & mis) o_MEM_misaligned <= 1'b1;
      end
    end
  end

endmodule
